// File: rtl/als_light_filter_pkg.sv
// Shared constants and helpers for the ambient-light filter: data widths, default
// thresholds and timeout, plus the hysteresis decision used by the top.
package als_light_filter_pkg;

   localparam int         ALS_BYTE_W         = 8;
   localparam int         CLK_HZ             = 100_000_000;
   localparam int         DEF_AVG_LOG2       = 3;
   localparam logic [7:0] DEF_TH_HI          = 8'd160;
   localparam logic [7:0] DEF_TH_LO          = 8'd96;
   localparam int         DEF_TIMEOUT_CYCLES = 2_000_000;  // 20 ms at CLK_HZ

   // Between the thresholds the previous flag is kept.
   function automatic logic hyst_next(input logic       cur,
                                      input logic [7:0] avg,
                                      input logic [7:0] th_hi,
                                      input logic [7:0] th_lo);
      if (avg >= th_hi) return 1'b1;
      if (avg <= th_lo) return 1'b0;
      return cur;
   endfunction

endpackage

// File: rtl/als_light_filter_if.sv
// Sensor-to-filter bundle: raw SPI reader byte/valid in, filtered light results out.
interface als_light_filter_if;
   import als_light_filter_pkg::*;

   // i_RX_DV is a valid-only pulse from the sclk domain (no ready): the byte is stable
   // while it is high, each rising edge is one sample, and the consumer cannot stall it.
   logic [ALS_BYTE_W-1:0] i_RX_Byte;
   logic                  i_RX_DV;
   logic [ALS_BYTE_W-1:0] o_avg;
   logic                  o_avg_valid;
   logic                  o_sample_stb;
   logic                  o_bright;
   logic                  o_stale;

   modport master (output i_RX_Byte, i_RX_DV,
                   input  o_avg, o_avg_valid, o_sample_stb, o_bright, o_stale);

   modport slave  (input  i_RX_Byte, i_RX_DV,
                   output o_avg, o_avg_valid, o_sample_stb, o_bright, o_stale);

endinterface

// File: rtl/als_light_filter_sync_edge_det.sv
// Two-flop synchronizer plus rising-edge pulse for a slow flag from another clock domain.
module als_light_filter_sync_edge_det #(
   parameter logic HIST_RST = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic pulse
);

   logic       s1, s2, s3;
   logic [1:0] prime;

   // The history flop keeps its reset value until s2 carries a real post-reset sample,
   // so a flag that is already high at reset release never produces a pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= HIST_RST;
         prime <= 2'b00;
      end else begin
         s1    <= async_in;
         s2    <= s1;
         prime <= {prime[0], 1'b1};
         if (prime[1]) s3 <= s2;
      end
   end

   assign pulse = s2 & ~s3;

endmodule

// File: rtl/als_light_filter.sv
// Ambient-light filter: moving average over the last N samples, hysteresis bright flag,
// and a stale-sensor flag when samples stop arriving.
module als_light_filter
   import als_light_filter_pkg::*;
#(
   parameter int         AVG_LOG2       = DEF_AVG_LOG2,
   parameter logic [7:0] TH_HI          = DEF_TH_HI,
   parameter logic [7:0] TH_LO          = DEF_TH_LO,
   parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   als_light_filter_if.slave  bus
);

   localparam int N  = 1 << AVG_LOG2;
   localparam int SW = ALS_BYTE_W + AVG_LOG2;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AVG_LOG2:0] FULL    = (AVG_LOG2 + 1)'(N);
   localparam logic [CW-1:0]     TO_SAT  = CW'(TIMEOUT_CYCLES);

   logic                  stb;
   logic [ALS_BYTE_W-1:0] win [N];
   logic [AVG_LOG2-1:0]   wr_ptr;
   logic [AVG_LOG2:0]     fill;
   logic [SW-1:0]         sum;
   logic [SW-1:0]         new_ext;
   logic [SW-1:0]         old_ext;
   logic                  upd;
   logic [CW-1:0]         tcnt;

   als_light_filter_sync_edge_det #(.HIST_RST(1'b1)) u_dv_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (bus.i_RX_DV),
      .pulse    (stb)
   );

   assign new_ext = SW'(bus.i_RX_Byte);
   assign old_ext = SW'(win[wr_ptr]);

   // Sample storage is never cleared; the fill count hides stale entries after reset.
   always_ff @(posedge clk) begin
      if (stb && !rst) win[wr_ptr] <= bus.i_RX_Byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr           <= '0;
         fill             <= '0;
         sum              <= '0;
         upd              <= 1'b0;
         tcnt             <= '0;
         bus.o_avg        <= '0;
         bus.o_avg_valid  <= 1'b0;
         bus.o_sample_stb <= 1'b0;
         bus.o_bright     <= 1'b0;
      end else begin
         upd              <= stb;
         bus.o_sample_stb <= upd;

         if (stb) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill == FULL) begin
               sum <= sum + new_ext - old_ext;
            end else begin
               sum  <= sum + new_ext;
               fill <= fill + 1'b1;
            end
         end

         // Results follow one cycle after the window update so they see the new sum.
         if (upd) begin
            bus.o_avg <= sum[SW-1:AVG_LOG2];
            if (fill == FULL) begin
               bus.o_avg_valid <= 1'b1;
               bus.o_bright    <= hyst_next(bus.o_bright, sum[SW-1:AVG_LOG2], TH_HI, TH_LO);
            end
         end

         if (stb)                tcnt <= '0;
         else if (tcnt != TO_SAT) tcnt <= tcnt + 1'b1;
      end
   end

   assign bus.o_stale = (tcnt == TO_SAT);

endmodule
